logic_unit_acc: RTL

LOGIC_UNIT_ACC -- requirements
Module: logic_unit_acc

---
 rtl/logic_unit_acc_pkg.sv | 18 +
 rtl/logic_unit_acc_if.sv | 32 +++
 rtl/logic_unit_acc_op.sv | 25 ++
 rtl/logic_unit_acc.sv | 124 ++++++++++++
 4 files changed

// File: rtl/logic_unit_acc_pkg.sv
// Shared definitions for the bitwise logic unit / accumulator:
// operation encodings and the FSM state encoding.
package logic_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        OUT  = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_acc_if.sv
// Beat/result handshake bundle between a producer/consumer (master) and
// the logic unit (slave).
interface logic_unit_acc_if #(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             zero;

    modport master (
        output in_valid, op, mode, A, B, last, out_ready,
        input  in_ready, out_valid, res, count, zero
    );

    modport slave (
        input  in_valid, op, mode, A, B, last, out_ready,
        output in_ready, out_valid, res, count, zero
    );

endinterface

// File: rtl/logic_unit_acc_op.sv
// Combinational bitwise operator shared by the single-shot and
// accumulate datapaths.
module logic_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_t              op,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives z and no latch is inferred.
        z = '0;
        unique case (op)
            OP_AND: z = x & y;
            OP_OR:  z = x | y;
            OP_XOR: z = x ^ y;
            OP_NOR: z = ~(x | y);
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with single-shot and accumulate-burst modes; one
// shared operator, registered result with valid/ready on both sides.
module logic_unit_acc
    import logic_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  MAX_LEN = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input logic             clk,
    input logic             rst,
    logic_unit_acc_if.slave bus
);

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    beats, beats_d, beats_inc;
    logic [CW-1:0]    count_q, count_d;
    op_t              op_l, op_d;
    logic             mode_l, mode_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready;
    logic             accept;
    logic             acc_path;
    logic [WIDTH-1:0] op_x, op_y, op_z;
    op_t              op_sel;

    // A held result can be replaced in the same cycle it is delivered.
    assign in_ready  = (state != OUT) || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign beats_inc = beats + CW'(1);

    // Mid-burst the operator folds A into the accumulator with the latched op.
    assign acc_path = (state == ACC) && mode_l;
    assign op_x     = acc_path ? acc  : bus.A;
    assign op_y     = acc_path ? bus.A : bus.B;
    assign op_sel   = acc_path ? op_l : op_t'(bus.op);

    logic_op #(.WIDTH(WIDTH)) u_op (
        .x  (op_x),
        .y  (op_y),
        .op (op_sel),
        .z  (op_z)
    );

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        beats_d     = beats;
        res_d       = res_q;
        count_d     = count_q;
        op_d        = op_l;
        mode_d      = mode_l;
        out_valid_d = out_valid_q;

        unique case (state)
            IDLE, OUT: begin
                if (state == OUT && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept) begin
                    if (!bus.mode || bus.last) begin
                        res_d       = op_z;
                        count_d     = CW'(1);
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        acc_d   = op_z;
                        beats_d = CW'(1);
                        op_d    = op_t'(bus.op);
                        mode_d  = 1'b1;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d   = op_z;
                    beats_d = beats_inc;
                    if (bus.last || beats_inc == CW'(MAX_LEN)) begin
                        res_d       = op_z;
                        count_d     = beats_inc;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            beats       <= '0;
            res_q       <= '0;
            count_q     <= '0;
            op_l        <= OP_AND;
            mode_l      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            beats       <= beats_d;
            res_q       <= res_d;
            count_q     <= count_d;
            op_l        <= op_d;
            mode_l      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.count     = count_q;
    assign bus.zero      = (res_q == '0);

endmodule
